// File: rtl/axis_segout_ring_fifo.sv
// rtl/axis_segout_ring_fifo.sv - wide AXI-Stream input split into independently drained per-lane ring buffers
module axis_segout_ring_fifo #(
  parameter  int AXIS_BUS_WIDTH     = 64,
  parameter  int AXIS_USER_WIDTH    = 4,
  parameter  int NUM_SEGMENTS       = 4,
  parameter  int BUFFER_DEPTH       = 4,
  parameter  int ALMOST_FULL_THRESH = 3,
  localparam int SEG_WIDTH          = AXIS_BUS_WIDTH / NUM_SEGMENTS,
  localparam int SEG_BYTES          = SEG_WIDTH / 8,
  localparam int CBITS              = $clog2(BUFFER_DEPTH + 1)
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [AXIS_BUS_WIDTH-1:0]   axis_in_tdata,
  input  logic [AXIS_USER_WIDTH-1:0]  axis_in_tuser,
  input  logic [AXIS_BUS_WIDTH/8-1:0] axis_in_tkeep,
  input  logic                        axis_in_tlast,
  input  logic                        axis_in_tvalid,
  output logic                        axis_in_tready,
  output logic [SEG_WIDTH-1:0]        axis_out_tdata       [NUM_SEGMENTS],
  output logic [SEG_BYTES-1:0]        axis_out_tkeep       [NUM_SEGMENTS],
  output logic                        axis_out_tvalid      [NUM_SEGMENTS],
  input  logic                        axis_out_tready      [NUM_SEGMENTS],
  output logic [AXIS_USER_WIDTH-1:0]  axis_out_tuser,
  output logic                        axis_out_tlast,
  output logic [SEG_BYTES-1:0]        axis_out_next_tkeep  [NUM_SEGMENTS],
  output logic                        axis_out_next_tvalid [NUM_SEGMENTS],
  output logic [CBITS-1:0]            seg_count            [NUM_SEGMENTS],
  output logic                        almost_full,
  input  logic                        flush
);
  localparam int PBITS = $clog2(BUFFER_DEPTH);
  localparam int LAST  = NUM_SEGMENTS - 1;

  if (AXIS_BUS_WIDTH % (8 * NUM_SEGMENTS) != 0) begin : g_bad_width
    $error("AXIS_BUS_WIDTH must be divisible by 8*NUM_SEGMENTS");
  end
  if (BUFFER_DEPTH < 2) begin : g_bad_depth
    $error("BUFFER_DEPTH must be at least 2");
  end
  if (ALMOST_FULL_THRESH < 1 || ALMOST_FULL_THRESH > BUFFER_DEPTH) begin : g_bad_thresh
    $error("ALMOST_FULL_THRESH must lie in 1..BUFFER_DEPTH");
  end

  logic [PBITS-1:0]           rd_ptr   [NUM_SEGMENTS];
  logic [PBITS-1:0]           wr_ptr   [NUM_SEGMENTS];
  logic [CBITS-1:0]           count    [NUM_SEGMENTS];
  logic [SEG_WIDTH-1:0]       data_mem [NUM_SEGMENTS][BUFFER_DEPTH];
  logic [SEG_BYTES-1:0]       keep_mem [NUM_SEGMENTS][BUFFER_DEPTH];
  // Sideband is only ever presented from the last lane, so it lives beside that lane's ring
  logic [AXIS_USER_WIDTH-1:0] user_mem [BUFFER_DEPTH];
  logic                       last_mem [BUFFER_DEPTH];
  logic                       push;
  logic [NUM_SEGMENTS-1:0]    pop;

  function automatic logic [PBITS-1:0] ptr_inc(input logic [PBITS-1:0] p);
    return (p == PBITS'(BUFFER_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    axis_in_tready = !flush;
    almost_full    = 1'b0;
    pop            = '0;
    for (int j = 0; j < NUM_SEGMENTS; j++) begin
      if (count[j] >= CBITS'(BUFFER_DEPTH))       axis_in_tready = 1'b0;
      if (count[j] >= CBITS'(ALMOST_FULL_THRESH)) almost_full    = 1'b1;
      pop[j] = (count[j] != '0) && axis_out_tready[j];
    end
  end

  assign push = axis_in_tvalid && axis_in_tready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int j = 0; j < NUM_SEGMENTS; j++) begin
        rd_ptr[j] <= '0;
        wr_ptr[j] <= '0;
        count[j]  <= '0;
      end
    end else if (flush) begin
      for (int j = 0; j < NUM_SEGMENTS; j++) begin
        rd_ptr[j] <= '0;
        wr_ptr[j] <= '0;
        count[j]  <= '0;
      end
    end else begin
      for (int j = 0; j < NUM_SEGMENTS; j++) begin
        if (push)   wr_ptr[j] <= ptr_inc(wr_ptr[j]);
        if (pop[j]) rd_ptr[j] <= ptr_inc(rd_ptr[j]);
        if (push && !pop[j])      count[j] <= count[j] + 1'b1;
        else if (!push && pop[j]) count[j] <= count[j] - 1'b1;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (push) begin
      for (int j = 0; j < NUM_SEGMENTS; j++) begin
        data_mem[j][wr_ptr[j]] <= axis_in_tdata[j*SEG_WIDTH +: SEG_WIDTH];
        keep_mem[j][wr_ptr[j]] <= axis_in_tkeep[j*SEG_BYTES +: SEG_BYTES];
      end
      user_mem[wr_ptr[LAST]] <= axis_in_tuser;
      last_mem[wr_ptr[LAST]] <= axis_in_tlast;
    end
  end

  // Outputs are driven purely from registered state; empty lanes present zeros
  always_comb begin
    for (int j = 0; j < NUM_SEGMENTS; j++) begin
      axis_out_tvalid[j]      = (count[j] != '0);
      axis_out_tdata[j]       = (count[j] != '0) ? data_mem[j][rd_ptr[j]] : '0;
      axis_out_tkeep[j]       = (count[j] != '0) ? keep_mem[j][rd_ptr[j]] : '0;
      axis_out_next_tvalid[j] = (count[j] >= CBITS'(2));
      axis_out_next_tkeep[j]  = (count[j] >= CBITS'(2)) ? keep_mem[j][ptr_inc(rd_ptr[j])] : '0;
      seg_count[j]            = count[j];
    end
    axis_out_tuser = (count[LAST] != '0) ? user_mem[rd_ptr[LAST]] : '0;
    axis_out_tlast = (count[LAST] != '0) ? last_mem[rd_ptr[LAST]] : 1'b0;
  end
endmodule

// File: tb/tb_axis_segout_ring_fifo.sv
// tb/tb_axis_segout_ring_fifo.sv - queue-model bench for axis_segout_ring_fifo (depth 4 main, depth 3 wrap)
module tb_axis_segout_ring_fifo;
  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic [3:0]  u;
    logic        l;
  } ent_t;

  logic aclk    = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic [255:0] a_tdata = '0;
  logic [3:0]   a_tuser = '0;
  logic [31:0]  a_tkeep = '0;
  logic         a_tlast = 1'b0, a_tvalid = 1'b0, a_tready, a_flush = 1'b0;
  logic [63:0]  a_odata [4];
  logic [7:0]   a_okeep [4], a_nkeep [4];
  logic         a_ovalid [4], a_nvalid [4];
  logic         a_oready [4] = '{default: 1'b0};
  logic [3:0]   a_ouser;
  logic         a_olast, a_af;
  logic [2:0]   a_cnt [4];

  logic [255:0] b_tdata = '0;
  logic [3:0]   b_tuser = '0;
  logic [31:0]  b_tkeep = '0;
  logic         b_tlast = 1'b0, b_tvalid = 1'b0, b_tready, b_flush = 1'b0;
  logic [63:0]  b_odata [4];
  logic [7:0]   b_okeep [4], b_nkeep [4];
  logic         b_ovalid [4], b_nvalid [4];
  logic         b_oready [4] = '{default: 1'b0};
  logic [3:0]   b_ouser;
  logic         b_olast, b_af;
  logic [1:0]   b_cnt [4];

  axis_segout_ring_fifo #(.AXIS_BUS_WIDTH(256), .AXIS_USER_WIDTH(4), .NUM_SEGMENTS(4),
                          .BUFFER_DEPTH(4), .ALMOST_FULL_THRESH(3)) dut_a (
    .aclk(aclk), .aresetn(aresetn),
    .axis_in_tdata(a_tdata), .axis_in_tuser(a_tuser), .axis_in_tkeep(a_tkeep),
    .axis_in_tlast(a_tlast), .axis_in_tvalid(a_tvalid), .axis_in_tready(a_tready),
    .axis_out_tdata(a_odata), .axis_out_tkeep(a_okeep), .axis_out_tvalid(a_ovalid),
    .axis_out_tready(a_oready), .axis_out_tuser(a_ouser), .axis_out_tlast(a_olast),
    .axis_out_next_tkeep(a_nkeep), .axis_out_next_tvalid(a_nvalid),
    .seg_count(a_cnt), .almost_full(a_af), .flush(a_flush));

  axis_segout_ring_fifo #(.AXIS_BUS_WIDTH(256), .AXIS_USER_WIDTH(4), .NUM_SEGMENTS(4),
                          .BUFFER_DEPTH(3), .ALMOST_FULL_THRESH(2)) dut_b (
    .aclk(aclk), .aresetn(aresetn),
    .axis_in_tdata(b_tdata), .axis_in_tuser(b_tuser), .axis_in_tkeep(b_tkeep),
    .axis_in_tlast(b_tlast), .axis_in_tvalid(b_tvalid), .axis_in_tready(b_tready),
    .axis_out_tdata(b_odata), .axis_out_tkeep(b_okeep), .axis_out_tvalid(b_ovalid),
    .axis_out_tready(b_oready), .axis_out_tuser(b_ouser), .axis_out_tlast(b_olast),
    .axis_out_next_tkeep(b_nkeep), .axis_out_next_tvalid(b_nvalid),
    .seg_count(b_cnt), .almost_full(b_af), .flush(b_flush));

  int   n_chk = 0, n_err = 0;
  int   b_pop_cnt [4] = '{default: 0};
  ent_t qa [4][$];
  ent_t qb [4][$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Model: each lane is a queue; outputs follow from queue contents alone
  initial begin
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        for (int j = 0; j < 4; j++) begin qa[j].delete(); qb[j].delete(); end
      end
      begin
        logic ra, rb, afa, afb;
        ent_t h, n;
        ra = !a_flush; rb = !b_flush; afa = 1'b0; afb = 1'b0;
        for (int j = 0; j < 4; j++) begin
          if (qa[j].size() >= 4) ra = 1'b0;
          if (qb[j].size() >= 3) rb = 1'b0;
          if (qa[j].size() >= 3) afa = 1'b1;
          if (qb[j].size() >= 2) afb = 1'b1;
        end
        chk("a_in_tready", a_tready, ra);
        chk("a_almost_full", a_af, afa);
        chk("b_in_tready", b_tready, rb);
        chk("b_almost_full", b_af, afb);
        for (int j = 0; j < 4; j++) begin
          h = '0; n = '0;
          if (qa[j].size() > 0) h = qa[j][0];
          if (qa[j].size() > 1) n = qa[j][1];
          chk($sformatf("a_tvalid[%0d]", j), a_ovalid[j], qa[j].size() > 0);
          chk($sformatf("a_tdata[%0d]", j), a_odata[j], h.d);
          chk($sformatf("a_tkeep[%0d]", j), a_okeep[j], h.k);
          chk($sformatf("a_next_tvalid[%0d]", j), a_nvalid[j], qa[j].size() > 1);
          chk($sformatf("a_next_tkeep[%0d]", j), a_nkeep[j], n.k);
          chk($sformatf("a_seg_count[%0d]", j), a_cnt[j], qa[j].size());
          if (j == 3) begin
            chk("a_tuser", a_ouser, h.u);
            chk("a_tlast", a_olast, h.l);
          end
          h = '0; n = '0;
          if (qb[j].size() > 0) h = qb[j][0];
          if (qb[j].size() > 1) n = qb[j][1];
          chk($sformatf("b_tvalid[%0d]", j), b_ovalid[j], qb[j].size() > 0);
          chk($sformatf("b_tdata[%0d]", j), b_odata[j], h.d);
          chk($sformatf("b_tkeep[%0d]", j), b_okeep[j], h.k);
          chk($sformatf("b_next_tkeep[%0d]", j), b_nkeep[j], n.k);
          chk($sformatf("b_seg_count[%0d]", j), b_cnt[j], qb[j].size());
          if (j == 3) begin
            chk("b_tuser", b_ouser, h.u);
            chk("b_tlast", b_olast, h.l);
          end
        end
        if (aresetn && !a_flush) begin
          for (int j = 0; j < 4; j++) if (qa[j].size() > 0 && a_oready[j]) void'(qa[j].pop_front());
          if (a_tvalid && ra)
            for (int j = 0; j < 4; j++) qa[j].push_back({a_tdata[j*64 +: 64], a_tkeep[j*8 +: 8], a_tuser, a_tlast});
        end else begin
          for (int j = 0; j < 4; j++) qa[j].delete();
        end
        if (aresetn && !b_flush) begin
          for (int j = 0; j < 4; j++)
            if (qb[j].size() > 0 && b_oready[j]) begin void'(qb[j].pop_front()); b_pop_cnt[j]++; end
          if (b_tvalid && rb)
            for (int j = 0; j < 4; j++) qb[j].push_back({b_tdata[j*64 +: 64], b_tkeep[j*8 +: 8], b_tuser, b_tlast});
        end
      end
    end
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic a_beat(input logic [31:0] keep, input logic last);
    a_tdata = rnd256(); a_tkeep = keep; a_tuser = 4'($urandom); a_tlast = last; a_tvalid = 1'b1;
  endtask

  initial begin
    step();
    chk("rst_tready", a_tready, 1'b1);
    chk("rst_count0", a_cnt[0], 0);
    chk("rst_af", a_af, 1'b0);
    aresetn = 1'b1;
    step();

    // Fill with all lanes stalled
    for (int i = 0; i < 4; i++) begin
      a_beat(32'hFFFF_FFFF, i == 3);
      step();
      if (i == 1) chk("fill_af_at2", a_af, 1'b0);
      if (i == 2) begin chk("fill_af_at3", a_af, 1'b1); chk("fill_cnt3", a_cnt[0], 3); end
    end
    a_tvalid = 1'b0;
    chk("fill_tready_low", a_tready, 1'b0);
    for (int j = 0; j < 4; j++) chk($sformatf("fill_cnt[%0d]", j), a_cnt[j], 4);

    // Skewed drain
    a_oready[0] = 1'b1;
    repeat (3) step();
    a_oready[0] = 1'b0;
    chk("skew_cnt0", a_cnt[0], 1);
    chk("skew_cnt1", a_cnt[1], 4);
    chk("skew_cnt3", a_cnt[3], 4);
    chk("skew_tready", a_tready, 1'b0);
    a_oready[1] = 1'b1; a_oready[2] = 1'b1; a_oready[3] = 1'b1;
    step();
    chk("skew_cnt2_after", a_cnt[2], 3);
    chk("skew_tready_after", a_tready, 1'b1);
    a_oready = '{default: 1'b1};
    repeat (4) step();
    chk("drain_cnt3", a_cnt[3], 0);
    a_oready = '{default: 1'b0};

    // Peek at second entry
    a_beat(32'hFFFF_FFFF, 1'b0); step();
    a_beat(32'h0000_000F, 1'b1); step();
    a_tvalid = 1'b0;
    chk("peek_head", a_okeep[0], 8'hFF);
    chk("peek_next", a_nkeep[0], 8'h0F);
    a_oready[0] = 1'b1; step(); a_oready[0] = 1'b0;
    chk("peek_head_after", a_okeep[0], 8'h0F);
    chk("peek_next_after", a_nkeep[0], 8'h00);
    chk("peek_nvalid_after", a_nvalid[0], 1'b0);

    // Flush with concurrent push and pop
    a_beat(32'hFFFF_FFFF, 1'b1); a_oready[0] = 1'b1; a_flush = 1'b1;
    #1 chk("flush_tready", a_tready, 1'b0);
    step();
    a_flush = 1'b0; a_tvalid = 1'b0; a_oready[0] = 1'b0;
    for (int j = 0; j < 4; j++) chk($sformatf("flush_cnt[%0d]", j), a_cnt[j], 0);
    chk("flush_tvalid0", a_ovalid[0], 1'b0);
    step();
    chk("flush_absent", a_ovalid[3], 1'b0);

    // Asynchronous reset with a full FIFO
    for (int i = 0; i < 4; i++) begin a_beat(32'hFFFF_FFFF, 1'b1); step(); end
    a_tvalid = 1'b0;
    chk("areset_full", a_cnt[3], 4);
    #2 aresetn = 1'b0;
    #1;
    chk("areset_tvalid", a_ovalid[0], 1'b0);
    chk("areset_tdata", a_odata[2], 0);
    chk("areset_tlast", a_olast, 1'b0);
    chk("areset_cnt", a_cnt[1], 0);
    chk("areset_af", a_af, 1'b0);
    chk("areset_tready", a_tready, 1'b1);
    step();
    aresetn = 1'b1;
    step();
    chk("release_tready", a_tready, 1'b1);

    // Wrap on depth-3 instance with all lanes ready
    b_oready = '{default: 1'b1};
    for (int i = 0; i < 10; i++) begin
      b_tdata = rnd256(); b_tkeep = $urandom; b_tuser = 4'($urandom); b_tlast = (i == 9); b_tvalid = 1'b1;
      step();
    end
    b_tvalid = 1'b0;
    repeat (3) step();
    chk("wrap_pops0", b_pop_cnt[0], 10);
    chk("wrap_pops3", b_pop_cnt[3], 10);

    // Randomised traffic on both instances
    for (int c = 0; c < 3000; c++) begin
      a_tdata = rnd256(); a_tkeep = $urandom; a_tuser = 4'($urandom); a_tlast = 1'($urandom);
      a_tvalid = ($urandom_range(0, 9) < 7);
      a_flush  = ($urandom_range(0, 63) == 0);
      b_tdata = rnd256(); b_tkeep = $urandom; b_tuser = 4'($urandom); b_tlast = 1'($urandom);
      b_tvalid = ($urandom_range(0, 9) < 6);
      for (int j = 0; j < 4; j++) begin
        a_oready[j] = ($urandom_range(0, 9) < 4 + j);
        b_oready[j] = ($urandom_range(0, 9) < 5);
      end
      step();
    end
    a_tvalid = 1'b0; b_tvalid = 1'b0; a_flush = 1'b0;
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
